// File: rtl/ibpu_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibpu_rx_pkg
//  Description : Shared types and constants for the pulled-up pad receiver
//                (filter FSM state encoding, idle level, glitch saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
package ibpu_rx_pkg;

    // Qualification FSM: either the line is settled, or a candidate level is
    // being timed against the filter length.
    typedef enum logic [0:0] {
        STABLE = 1'b0,
        QUAL   = 1'b1
    } rx_state_e;

    // Level the line rests at through the pull-up; also every level reset value.
    localparam logic IDLE_LVL = 1'b1;

    // Ceiling of the rejected-glitch counter.
    localparam logic [7:0] GLITCH_MAX = 8'hFF;

    // Saturating increment of the glitch counter.
    function automatic logic [7:0] glitch_inc(input logic [7:0] cnt);
        return (cnt == GLITCH_MAX) ? cnt : cnt + 8'd1;
    endfunction

endpackage : ibpu_rx_pkg
`default_nettype wire

// File: rtl/ibpu_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : ibpu_sync2
//  Description : Two-flop synchronizer for an asynchronous pad level. Both
//                flops reset to the line idle level so reset never produces a
//                fake edge on the synchronized output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibpu_sync2 #(
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic CK,
    input  logic RSTN,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Two-stage capture of the asynchronous level; only s2 is used downstream.
    always_ff @(posedge CK) begin
        if (!RSTN) begin
            s1_q <= IDLE_LVL;
            s2_q <= IDLE_LVL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule : ibpu_sync2
`default_nettype wire

// File: rtl/ibpu_filter_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ibpu_filter_rx
//  Description : Receiver for a pulled-up shared pad line. Synchronizes the
//                pad, rejects pulses shorter than FILT_LEN+1 samples, drives a
//                clean level with registered rise/fall strobes, counts
//                rejected glitches and flags a line held low too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibpu_filter_rx
    import ibpu_rx_pkg::*;
#(
    parameter int FILT_W  = 4,
    parameter int STUCK_W = 16
) (
    input  logic               CK,
    input  logic               RSTN,
    input  logic               PAD_I,
    input  logic               EN,
    input  logic [FILT_W-1:0]  FILT_LEN,
    input  logic [STUCK_W-1:0] STUCK_LIM,
    input  logic               STUCK_CLR,
    output logic               Q,
    output logic               RISE,
    output logic               FALL,
    output logic               STUCK,
    output logic [7:0]         GLITCH_CNT
);

    // ------------------------------------------------------------------------
    // Synchronized pad level
    // ------------------------------------------------------------------------
    logic sync_lvl;

    ibpu_sync2 #(
        .IDLE_LVL (IDLE_LVL)
    ) u_sync (
        .CK   (CK),
        .RSTN (RSTN),
        .d_i  (PAD_I),
        .q_o  (sync_lvl)
    );

    // ------------------------------------------------------------------------
    // Filter state
    // ------------------------------------------------------------------------
    rx_state_e          state_q,  state_d;
    logic               cand_q,   cand_d;
    logic [FILT_W-1:0]  cnt_q,    cnt_d;
    logic               lvl_q,    lvl_d;
    logic               rise_q,   rise_d;
    logic               fall_q,   fall_d;
    logic [7:0]         glitch_q, glitch_d;

    // Stuck-low detector state
    logic [STUCK_W-1:0] stk_cnt_q, stk_cnt_d;
    logic               stuck_q,   stuck_d;

    // Qualification FSM: decides when the filtered level may follow the
    // synchronized level, and counts candidates that collapse early.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        lvl_d    = lvl_q;
        glitch_d = glitch_q;

        case (state_q)
            STABLE: begin
                if (sync_lvl != lvl_q) begin
                    if (!EN || (FILT_LEN == '0)) begin
                        // No qualification requested: follow immediately.
                        lvl_d = sync_lvl;
                    end else begin
                        state_d = QUAL;
                        cand_d  = sync_lvl;
                        cnt_d   = FILT_W'(1);
                    end
                end
            end

            QUAL: begin
                if (!EN) begin
                    // Filter switched off mid-candidate: adopt the current
                    // synchronized level without charging a glitch.
                    lvl_d   = sync_lvl;
                    state_d = STABLE;
                end else if (sync_lvl == cand_q) begin
                    // >= lets a shortened FILT_LEN commit right away.
                    if (cnt_q >= FILT_LEN) begin
                        lvl_d   = cand_q;
                        state_d = STABLE;
                    end else begin
                        cnt_d = cnt_q + FILT_W'(1);
                    end
                end else begin
                    // Candidate reverted before qualifying.
                    glitch_d = glitch_inc(glitch_q);
                    state_d  = STABLE;
                end
            end

            default: begin
                state_d = STABLE;
            end
        endcase
    end

    // Edge strobes are registered together with the level so each is visible
    // exactly in the first cycle the new level is.
    always_comb begin
        rise_d = lvl_d & ~lvl_q;
        fall_d = ~lvl_d & lvl_q;
    end

    // Stuck-low detector: counts consecutive low cycles of the filtered level
    // up to STUCK_LIM and latches a sticky flag when the limit is reached.
    always_comb begin
        stk_cnt_d = stk_cnt_q;
        stuck_d   = stuck_q;

        if (STUCK_CLR) begin
            // Clear beats a simultaneous set.
            stk_cnt_d = '0;
            stuck_d   = 1'b0;
        end else if ((STUCK_LIM == '0) || lvl_q) begin
            stk_cnt_d = '0;
        end else begin
            if (stk_cnt_q >= STUCK_LIM) begin
                stk_cnt_d = STUCK_LIM;
            end else begin
                stk_cnt_d = stk_cnt_q + STUCK_W'(1);
            end
            if (stk_cnt_d == STUCK_LIM) begin
                stuck_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset; reset abandons any
    // candidate and returns the line to its idle level.
    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state_q   <= STABLE;
            cand_q    <= IDLE_LVL;
            cnt_q     <= '0;
            lvl_q     <= IDLE_LVL;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            glitch_q  <= '0;
            stk_cnt_q <= '0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            glitch_q  <= glitch_d;
            stk_cnt_q <= stk_cnt_d;
            stuck_q   <= stuck_d;
        end
    end

    assign Q          = lvl_q;
    assign RISE       = rise_q;
    assign FALL       = fall_q;
    assign STUCK      = stuck_q;
    assign GLITCH_CNT = glitch_q;

endmodule : ibpu_filter_rx
`default_nettype wire

// File: tb/tb_ibpu_filter_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibpu_filter_rx
//  Description : Self-checking bench for ibpu_filter_rx. Stimulus pushes the
//                hand-derived expected outputs for each cycle into a queue; a
//                monitor on the falling edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ibpu_filter_rx;
    import ibpu_rx_pkg::*;

    localparam int FILT_W  = 4;
    localparam int STUCK_W = 16;

    logic               CK;
    logic               RSTN;
    logic               PAD_I;
    logic               EN;
    logic [FILT_W-1:0]  FILT_LEN;
    logic [STUCK_W-1:0] STUCK_LIM;
    logic               STUCK_CLR;
    logic               Q;
    logic               RISE;
    logic               FALL;
    logic               STUCK;
    logic [7:0]         GLITCH_CNT;

    ibpu_filter_rx #(
        .FILT_W  (FILT_W),
        .STUCK_W (STUCK_W)
    ) dut (
        .CK         (CK),
        .RSTN       (RSTN),
        .PAD_I      (PAD_I),
        .EN         (EN),
        .FILT_LEN   (FILT_LEN),
        .STUCK_LIM  (STUCK_LIM),
        .STUCK_CLR  (STUCK_CLR),
        .Q          (Q),
        .RISE       (RISE),
        .FALL       (FALL),
        .STUCK      (STUCK),
        .GLITCH_CNT (GLITCH_CNT)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct packed {
        logic [8*8-1:0] name;
        logic           q;
        logic           rise;
        logic           fall;
        logic           stuck;
        logic [7:0]     glitch;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    int             exp_glitch = 0;
    logic           exp_stuck  = 1'b0;
    logic [8*8-1:0] cur_name   = "reset";

    // Monitor: outputs of the edge just past are compared mid-cycle.
    always @(negedge CK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({Q, RISE, FALL, STUCK, GLITCH_CNT} !==
                {mon_e.q, mon_e.rise, mon_e.fall, mon_e.stuck, mon_e.glitch}) begin
                failures++;
                $display("FAIL %0s @%0t: got q=%b rise=%b fall=%b stuck=%b glitch=%0d, required q=%b rise=%b fall=%b stuck=%b glitch=%0d",
                         mon_e.name, $time, Q, RISE, FALL, STUCK, GLITCH_CNT,
                         mon_e.q, mon_e.rise, mon_e.fall, mon_e.stuck, mon_e.glitch);
            end
        end
    end

    // One cycle: wait for the edge, drive the pad for the next edge and
    // record what the outputs must show during this cycle.
    task automatic cyc(input logic pad, input logic eq, input logic er,
                       input logic ef, input logic es, input int eg);
        exp_t e;
        @(posedge CK);
        #1;
        PAD_I = pad;
        e.name   = cur_name;
        e.q      = eq;
        e.rise   = er;
        e.fall   = ef;
        e.stuck  = es;
        e.glitch = eg[7:0];
        sb.push_back(e);
    endtask

    task automatic bump_glitch();
        exp_glitch = (exp_glitch >= 255) ? 255 : exp_glitch + 1;
    endtask

    // Low pulse of p pad cycles with effective filter length l. A pulse of at
    // least l+1 samples passes: Q low from cycle 3+l to p+2+l. A shorter one
    // is counted as a glitch in cycle p+3.
    task automatic pulse(input int p, input int l);
        logic acc;
        acc = (p >= l + 1);
        for (int k = 0; k < p + l + 6; k++) begin
            if (!acc && k == p + 3) bump_glitch();
            cyc((k < p) ? 1'b0 : 1'b1,
                (acc && k >= 3 + l && k <= p + 2 + l) ? 1'b0 : 1'b1,
                acc && (k == p + 3 + l),
                acc && (k == 3 + l),
                exp_stuck, exp_glitch);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN      = 1'b0;
        PAD_I     = 1'b1;
        EN        = 1'b1;
        FILT_LEN  = 4'd3;
        STUCK_LIM = '0;
        STUCK_CLR = 1'b0;

        // Reset values, then a quiet line for 50 cycles.
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        RSTN = 1'b1;
        cur_name = "idle";
        for (int k = 0; k < 50; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Long low pulse passes with L=3.
        cur_name = "long_lo";
        pulse(10, 3);

        // Short pulses 1..3 rejected, 4 accepted.
        cur_name = "short";
        for (int p = 1; p <= 4; p++) pulse(p, 3);

        // Filter bypassed: a single-cycle pulse passes through.
        cur_name = "bypass";
        EN = 1'b0;
        pulse(1, 0);
        EN = 1'b1;

        // Zero filter length with filter enabled also passes immediately.
        cur_name = "len0";
        FILT_LEN = 4'd0;
        pulse(1, 0);
        FILT_LEN = 4'd3;

        // EN dropped while qualifying: Q follows at that edge, no glitch.
        cur_name = "en_drop";
        for (int k = 0; k < 16; k++) begin
            cyc((k < 8) ? 1'b0 : 1'b1,
                (k >= 4 && k <= 10) ? 1'b0 : 1'b1,
                k == 11, k == 4, 1'b0, exp_glitch);
            if (k == 3) EN = 1'b0;
        end
        EN = 1'b1;

        // Stuck detector: set after 20 low cycles, clear, re-set, disable.
        cur_name = "stuck";
        STUCK_LIM = 16'd20;
        for (int k = 0; k < 111; k++) begin
            cyc((k <= 100) ? 1'b0 : 1'b1,
                (k >= 6 && k <= 106) ? 1'b0 : 1'b1,
                k == 107, k == 6,
                (k >= 26 && k <= 35) || (k >= 56 && k <= 60),
                exp_glitch);
            if (k == 35) STUCK_CLR = 1'b1;
            if (k == 36) STUCK_CLR = 1'b0;
            if (k == 60) begin
                STUCK_LIM = '0;
                STUCK_CLR = 1'b1;
            end
            if (k == 61) STUCK_CLR = 1'b0;
        end

        // Glitch counter saturation.
        cur_name = "sat";
        for (int n = 0; n < 300; n++) pulse(1, 3);

        // Reset while qualifying a candidate.
        cur_name = "rst_qual";
        for (int k = 0; k < 16; k++) begin
            if (k == 4) exp_glitch = 0;
            cyc((k < 4) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_glitch);
            if (k == 3) RSTN = 1'b0;
            if (k == 4) begin
                RSTN = 1'b1;
                checks++;
                if (dut.state_q !== STABLE) begin
                    failures++;
                    $display("FAIL rst_state: got state=%0d, required state=%0d",
                             dut.state_q, STABLE);
                end
            end
        end

        // Let the monitor drain the queue, bounded.
        for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge CK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ibpu_filter_rx
`default_nettype wire

// File: doc/ibpu_filter_rx.md
# ibpu_filter_rx

Synchronous receiver for a pulled-up, tristated pad line: the input-side counterpart of our tristate pull-up output buffers. It samples the asynchronous pad level and synchronizes it. It rejects pulses shorter than a programmable qualification length, produces a clean level with one-cycle edge strobes, counts rejected glitches, and flags a line held low (stuck or contended) for too long. The block sits between the input pad cell and core logic on any pulled-up shared line.

## Interface
- FILT_W, 4: width of the filter length and qualification counter.
- STUCK_W, 16: width of the stuck-low limit and counter.
- CK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- PAD_I  in  1  asynchronous pad level; idles high through the pull-up.
- EN  in  1  filter enable; 0 = bypass qualification.
- FILT_LEN  in  FILT_W  consecutive stable synchronized samples required beyond the first (L).
- STUCK_LIM  in  STUCK_W  low-cycle limit for the stuck flag; 0 disables.
- STUCK_CLR  in  1  clears STUCK and the stuck counter.
- Q  out  1  filtered line level.
- RISE  out  1  one-cycle strobe, Q went 0->1.
- FALL  out  1  one-cycle strobe, Q went 1->0.
- STUCK  out  1  sticky: Q low for STUCK_LIM consecutive cycles.
- GLITCH_CNT  out  8  saturating count of rejected transitions.

## Operation
- Reset (RSTN=0 at a CK edge): sync flops=1, Q=1, RISE=FALL=0, STUCK=0, GLITCH_CNT=0, state STABLE, counters 0. Reset mid-qualification discards the candidate.
- Sync: two flops, s1<=PAD_I, s2<=s1. Only s2 feeds the FSM.
- FSM states are STABLE and QUAL.
  - STABLE, s2==Q: hold.
  - STABLE, s2!=Q, (EN=0 or L=0): Q<=s2 at this edge.
  - STABLE, s2!=Q, otherwise: go to QUAL, cand<=s2, cnt<=1.
  - QUAL, s2==cand, cnt>=L: Q<=cand, go to STABLE. Use >= so a mid-flight decrease of FILT_LEN commits at once.
  - QUAL, s2==cand, cnt<L: cnt<=cnt+1.
  - QUAL, s2!=cand: GLITCH_CNT<=min(GLITCH_CNT+1,255), go to STABLE.
  - EN falling while in QUAL: Q<=s2 at that edge, go to STABLE, no glitch count.
- RISE/FALL are registered. Each is high exactly during the first cycle Q shows the new value. At most one of them is high at a time.
- Stuck detector:
  - Counter increments each cycle Q==0, saturating at STUCK_LIM, and resets to 0 when Q==1.
  - STUCK sets when the counter reaches STUCK_LIM (nonzero) and stays set until STUCK_CLR or reset.
  - STUCK_CLR zeroes the counter. Clear wins over a simultaneous set; counting resumes the next cycle if Q is still 0.
  - STUCK_LIM=0: counter held at 0, STUCK never sets.
- GLITCH_CNT holds at 255. Only reset clears it.

## Timing
- PAD_I change captured into s1 at edge e0, s2 at e1.
- Q updates at edge e(2+L), where L=0 when EN=0.
- RISE/FALL are valid the same cycle as the new Q.
- The minimum accepted pulse is L+1 synchronized cycles. Shorter pulses are rejected and counted once each.
- STUCK rises STUCK_LIM cycles after the cycle Q first reads 0.
- FILT_LEN, STUCK_LIM and EN are sampled every cycle; changes take effect at the next edge.

## Structure
- Package ibpu_rx_pkg holds:
  - the state enum {STABLE, QUAL};
  - IDLE_LVL=1'b1, the pull-up idle level and reset value;
  - GLITCH_MAX=8'hFF.
- Sub-module ibpu_sync2 is the two-flop synchronizer with reset value parameter IDLE_LVL. The FSM, stuck detector and glitch counter live in the top module.

## Test plan
- Reset, then PAD_I=1 steady, EN=1, L=3: Q=1, no strobes, GLITCH_CNT=0, STUCK=0 for 50 cycles.
- L=3, PAD_I low for 10 cycles: FALL one cycle at e5 after capture edge e0, Q=0. Return high: RISE 5 edges after capture, Q=1.
- L=3, low pulses of 1, 2, 3 cycles: Q stays 1, no strobes, GLITCH_CNT=3. A 4-cycle pulse is accepted.
- EN=0, 1-cycle low pulse: Q low for exactly 1 cycle at e2, FALL then RISE, GLITCH_CNT unchanged.
- STUCK_LIM=20, PAD_I held low: STUCK=1 20 cycles after Q=0. STUCK_CLR pulsed with line still low: STUCK=0, then re-sets 20 cycles later. STUCK_LIM=0: never sets.
- 300 rejected glitches: GLITCH_CNT=255. Assert RSTN=0 mid-QUAL: next cycle Q=1, state STABLE, GLITCH_CNT=0.
